cpu8_core: RTL and testbench
============================

# cpu8_core

8-bit single-cycle processor core: instruction decode, control, 8×8 register file, ALU, branch/jump PC logic and a 256-byte data memory with busy-wait stalling. It sits between an external instruction memory (driven from `PC`, returning `INSTRUCTION`) and the system clock/reset. It contains the ALU, data_memory and reg_file functions as internal submodules.

## Interface
- `MEM_LATENCY`, 5, number of stall cycles (BUSYWAIT high) per data-memory access when stalling is compiled in; must be ≥1.
- `CLK  input  1  system clock; all state changes on rising edge.`
- `RESET  input  1  reset; synchronous, active-high; clock CLK.`
- `INSTRUCTION  input  32  instruction word for the current PC; combinational from external memory, valid before the next rising edge.`
- `PC  output  32  byte address of the current instruction.`

## Operation
- Fields: opcode [31:24]; rd [18:16]; branch offset [23:16]; rs [10:8]; rt [2:0]; imm [7:0].
- Opcodes: 0x00 loadi rd←imm; 0x01 mov rd←r[rt]; 0x02 add rd←r[rs]+r[rt]; 0x03 sub rd←r[rs]−r[rt]; 0x04 and; 0x05 or; 0x06 j; 0x07 beq rs,rt; 0x08 lwd rd←M[r[rt]]; 0x09 lwi rd←M[imm]; 0x0A swd M[r[rt]]←r[rs]; 0x0B swi M[imm]←r[rs]. Other opcodes: NOP (no writes, PC+4).
- Operand B = r[rt] or imm (loadi, lwi, swi); subtract/beq uses two's complement of r[rt] (8-bit, wraps).
- ALU ops: FORWARD (out=B; mov, loadi, loads, stores), ADD (add, sub, beq), AND, OR. 8-bit result, carry dropped. ZERO = (result==0).
- Memory address = ALU result (8 bits, 256 bytes). Load writes memory data to rd; all other writing ops write ALU result.
- Register file: 8×8 bits, two asynchronous read ports, one write port at rising edge; r0 is an ordinary register.
- PC: next = PC+4; j → PC+4+(sext(offset)<<2); beq taken (ZERO=1) → same target. Offset sign-extended from 8 to 32 bits; target arithmetic is 32-bit wrap-around.

## Timing
- Reset (sync, at rising edge with RESET=1): PC=0, all registers=0, all data memory bytes=0, stall counter=0, BUSYWAIT=0. RESET dominates any in-flight access; an aborted store does not write.
- Non-memory instruction: 1 cycle; register write and PC update at the same rising edge.
- Memory instruction: BUSYWAIT high combinationally from decode for MEM_LATENCY cycles; PC, registers and memory hold. Cycle MEM_LATENCY+1: BUSYWAIT low; at that edge the store commits or the load result is written to rd, PC advances, counter clears. Total MEM_LATENCY+1 cycles.
- Back-to-back memory instructions each pay full latency; no pipelining.
- Store then load to the same address: load returns the stored value.

## Configuration
- `CPU8_MEM_STALL_EN` defined: multi-cycle memory as above. Undefined: BUSYWAIT tied 0; reads asynchronous, writes at rising edge; every instruction takes 1 cycle; MEM_LATENCY ignored.

## Test plan
- Reset for 2 cycles, then loadi r4,5; loadi r5,3; loadi r3,1 → r4=5, r5=3, r3=1, PC=12 after 3 cycles.
- swi r4,0x00; swd r5,r3 → M[0]=5, M[1]=3; each takes MEM_LATENCY+1 cycles with PC stalled while BUSYWAIT=1.
- add r4,r4,r5; sub r5,r4,r5 → r4=8, r5=5; then lwi r6,0x00 → r6=5; lwd r7,r3 → r7=3.
- loadi r1,7; loadi r2,7; beq offset −2 from PC=0x10 → PC=0x0C; with r2=6 → PC=0x14; j offset +1 at 0x20 → PC=0x28.
- sub with r[rs]=2, r[rt]=5 → rd=0xFD; and 0xF0&0x3C → 0x30; or → 0xFC; mov r0←r[rt]=0xAA → r0=0xAA.
- Assert RESET mid swi stall → PC=0, target byte unchanged (0), BUSYWAIT=0 next cycle.

Source files
------------

// File: rtl/cpu8_core.sv
// cpu8_core: 8-bit single-cycle processor core.
// It decodes the instruction, drives an ALU, an 8x8 register file and a
// 256-byte data memory, and computes the next PC for branches and jumps.
//
// Ports:
//   CLK          system clock; all state changes on the rising edge
//   RESET        synchronous, active-high reset
//   INSTRUCTION  32-bit instruction word for the current PC (combinational)
//   PC           byte address of the current instruction
//
// Parameter:
//   MEM_LATENCY  number of BUSYWAIT cycles per data-memory access (>= 1)
//
// Build option:
//   CPU8_MEM_STALL_EN  when defined, every load or store stalls the core for
//                      MEM_LATENCY cycles and then commits. When undefined,
//                      BUSYWAIT is tied low and every instruction takes one
//                      cycle.

package cpu8_pkg;
    typedef enum logic [1:0] {
        ALU_FWD = 2'd0,
        ALU_ADD = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;
endpackage

// 8-bit ALU: forward, add, and, or. Carry out is dropped.
module cpu8_alu
    import cpu8_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  alu_op_e    op,
    output logic [7:0] result,
    output logic       zero
);
    always_comb begin
        result = b;
        case (op)
            ALU_FWD: result = b;
            ALU_ADD: result = a + b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            default: result = b;
        endcase
    end

    assign zero = (result == 8'd0);
endmodule

// 8x8 register file: two asynchronous read ports, one synchronous write port.
module cpu8_reg_file (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [2:0] rd_addr1,
    input  logic [2:0] rd_addr2,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic [7:0] rd_data1,
    output logic [7:0] rd_data2
);
    logic [7:0] regs [8];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'd0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data1 = regs[rd_addr1];
    assign rd_data2 = regs[rd_addr2];
endmodule

// 256-byte data memory: asynchronous read, write on the rising edge.
module cpu8_data_memory (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] addr,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic [7:0] rd_data
);
    logic [7:0] mem [256];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
        end else if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];
endmodule

module cpu8_core
    import cpu8_pkg::*;
#(
    parameter int MEM_LATENCY = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    output logic [31:0] PC
);
    logic [7:0] opcode;
    logic [7:0] offset;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [7:0] imm;

    logic       imm_sel;
    logic       negate;
    alu_op_e    alu_op;
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       jump;
    logic       branch;

    logic [7:0] rs_data;
    logic [7:0] rt_data;
    logic [7:0] operand_b;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic [7:0] mem_rdata;
    logic [7:0] wb_data;
    logic       busywait;

    logic [31:0] pc_plus4;
    logic [31:0] pc_target;
    logic [31:0] pc_next;

    logic unused_instr_bits;

    assign opcode = INSTRUCTION[31:24];
    assign offset = INSTRUCTION[23:16];
    assign rd     = INSTRUCTION[18:16];
    assign rs     = INSTRUCTION[10:8];
    assign rt     = INSTRUCTION[2:0];
    assign imm    = INSTRUCTION[7:0];
    assign unused_instr_bits = ^INSTRUCTION[15:11];

    always_comb begin
        imm_sel = 1'b0;
        negate  = 1'b0;
        alu_op  = ALU_FWD;
        reg_we  = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        jump    = 1'b0;
        branch  = 1'b0;
        case (opcode)
            8'h00: begin imm_sel = 1'b1; reg_we = 1'b1; end
            8'h01: reg_we = 1'b1;
            8'h02: begin alu_op = ALU_ADD; reg_we = 1'b1; end
            8'h03: begin alu_op = ALU_ADD; negate = 1'b1; reg_we = 1'b1; end
            8'h04: begin alu_op = ALU_AND; reg_we = 1'b1; end
            8'h05: begin alu_op = ALU_OR;  reg_we = 1'b1; end
            8'h06: jump = 1'b1;
            8'h07: begin alu_op = ALU_ADD; negate = 1'b1; branch = 1'b1; end
            8'h08: begin mem_rd = 1'b1; reg_we = 1'b1; end
            8'h09: begin mem_rd = 1'b1; reg_we = 1'b1; imm_sel = 1'b1; end
            8'h0A: mem_wr = 1'b1;
            8'h0B: begin mem_wr = 1'b1; imm_sel = 1'b1; end
            default: ;
        endcase
    end

    assign operand_b = imm_sel ? imm : rt_data;
    // sub and beq add the two's complement, so equality shows up as ZERO.
    assign alu_b     = negate ? (8'd0 - operand_b) : operand_b;
    assign wb_data   = mem_rd ? mem_rdata : alu_result;

    cpu8_reg_file u_rf (
        .CLK      (CLK),
        .RESET    (RESET),
        .rd_addr1 (rs),
        .rd_addr2 (rt),
        .wr_addr  (rd),
        .wr_data  (wb_data),
        .wr_en    (reg_we && !busywait),
        .rd_data1 (rs_data),
        .rd_data2 (rt_data)
    );

    cpu8_alu u_alu (
        .a      (rs_data),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    cpu8_data_memory u_dmem (
        .CLK     (CLK),
        .RESET   (RESET),
        .addr    (alu_result),
        .wr_data (rs_data),
        .wr_en   (mem_wr && !busywait),
        .rd_data (mem_rdata)
    );

`ifdef CPU8_MEM_STALL_EN
    // Down-counter of remaining stall cycles. The first cycle of an access
    // is busy with the counter idle; it loads MEM_LATENCY-1 and counts to
    // terminal count 0, where BUSYWAIT drops and the access commits.
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    logic          mem_access;
    logic          stall_active;
    logic [CW-1:0] stall_cnt;

    assign mem_access = mem_rd || mem_wr;
    assign busywait   = mem_access && !(stall_active && (stall_cnt == '0));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_active <= 1'b0;
            stall_cnt    <= '0;
        end else if (mem_access) begin
            if (!stall_active) begin
                stall_active <= 1'b1;
                stall_cnt    <= CW'(MEM_LATENCY - 1);
            end else if (stall_cnt == '0) begin
                stall_active <= 1'b0;
            end else begin
                stall_cnt <= stall_cnt - CW'(1);
            end
        end else begin
            stall_active <= 1'b0;
            stall_cnt    <= '0;
        end
    end
`else
    // Without stalling the latency parameter has no effect.
    localparam int unused_mem_latency = MEM_LATENCY;
    assign busywait = 1'b0;
`endif

    assign pc_plus4  = PC + 32'd4;
    assign pc_target = pc_plus4 + {{22{offset[7]}}, offset, 2'b00};
    assign pc_next   = (jump || (branch && alu_zero)) ? pc_target : pc_plus4;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            PC <= 32'd0;
        end else if (!busywait) begin
            PC <= pc_next;
        end
    end
endmodule

// File: tb/tb_cpu8_core.sv
// Testbench for cpu8_core: a table of directed instructions with hand-derived
// results, hand-written branch/jump and reset-during-access sequences, and a
// random instruction stream checked against an instruction-level model.
module tb_cpu8_core;
    localparam int MEM_LAT = 5;
`ifdef CPU8_MEM_STALL_EN
    localparam int LAT = MEM_LAT;
`else
    localparam int LAT = 0;
`endif

    localparam logic [7:0] OP_LOADI = 8'h00, OP_MOV = 8'h01, OP_ADD = 8'h02,
                           OP_SUB = 8'h03, OP_AND = 8'h04, OP_OR = 8'h05,
                           OP_J = 8'h06, OP_BEQ = 8'h07, OP_LWD = 8'h08,
                           OP_LWI = 8'h09, OP_SWD = 8'h0A, OP_SWI = 8'h0B;
    localparam logic [31:0] NOP = 32'hFF00_0000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] INSTRUCTION = NOP;
    logic [31:0] PC;

    cpu8_core #(.MEM_LATENCY(MEM_LAT)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .INSTRUCTION (INSTRUCTION),
        .PC          (PC)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  m_reg [8];
    logic [7:0]  m_mem [256];
    logic [31:0] m_pc;
    logic        m_st_valid;
    logic [7:0]  m_st_addr;

    typedef struct {
        logic [31:0] instr;
        bit          chk_mem;
        logic [7:0]  idx;
        logic [7:0]  val;
        logic [31:0] pc;
    } vec_t;
    vec_t vecs [19];

    function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] hi,
                                        input logic [2:0] rs, input logic [7:0] lo);
        return {op, hi, 5'b0, rs, lo};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction-level reference: architectural effect of one instruction.
    task automatic model_step(input logic [31:0] instr);
        logic [7:0]  op, imm, off;
        logic [2:0]  rd, rs, rt;
        logic [31:0] jump_to;
        op  = instr[31:24];
        off = instr[23:16];
        rd  = instr[18:16];
        rs  = instr[10:8];
        rt  = instr[2:0];
        imm = instr[7:0];
        jump_to = m_pc + 32'(4 + 4 * int'($signed(off)));
        m_st_valid = 1'b0;
        case (op)
            OP_LOADI: m_reg[rd] = imm;
            OP_MOV:   m_reg[rd] = m_reg[rt];
            OP_ADD:   m_reg[rd] = 8'(m_reg[rs] + m_reg[rt]);
            OP_SUB:   m_reg[rd] = 8'(m_reg[rs] - m_reg[rt]);
            OP_AND:   m_reg[rd] = m_reg[rs] & m_reg[rt];
            OP_OR:    m_reg[rd] = m_reg[rs] | m_reg[rt];
            OP_LWD:   m_reg[rd] = m_mem[m_reg[rt]];
            OP_LWI:   m_reg[rd] = m_mem[imm];
            OP_SWD: begin
                m_mem[m_reg[rt]] = m_reg[rs];
                m_st_valid = 1'b1;
                m_st_addr  = m_reg[rt];
            end
            OP_SWI: begin
                m_mem[imm] = m_reg[rs];
                m_st_valid = 1'b1;
                m_st_addr  = imm;
            end
            default: ;
        endcase
        if (op == OP_J || (op == OP_BEQ && m_reg[rs] == m_reg[rt]))
            m_pc = jump_to;
        else
            m_pc = m_pc + 32'd4;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 8'd0;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'd0;
        m_pc = 32'd0;
        m_st_valid = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        INSTRUCTION = NOP;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
    endtask

    // Present one instruction, check the stall window, then let it retire.
    task automatic run_instr(input logic [31:0] instr);
        logic is_mem;
        INSTRUCTION = instr;
        is_mem = (instr[31:24] >= OP_LWD) && (instr[31:24] <= OP_SWI);
        #1;
        if (is_mem && LAT > 0) begin
            check("busy_start", {31'b0, dut.busywait}, 32'd1);
            for (int k = 1; k <= LAT; k++) begin
                @(posedge CLK);
                #1;
                check("stall_pc", PC, m_pc);
                check("stall_busy", {31'b0, dut.busywait}, (k < LAT) ? 32'd1 : 32'd0);
            end
        end else begin
            check("busy_idle", {31'b0, dut.busywait}, 32'd0);
        end
        @(posedge CLK);
        #1;
        model_step(instr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{ins(OP_LOADI, 8'd4, 3'd0, 8'd5),    1'b0, 8'd4, 8'd5,    32'h04};
        vecs[1]  = '{ins(OP_LOADI, 8'd5, 3'd0, 8'd3),    1'b0, 8'd5, 8'd3,    32'h08};
        vecs[2]  = '{ins(OP_LOADI, 8'd3, 3'd0, 8'd1),    1'b0, 8'd3, 8'd1,    32'h0C};
        vecs[3]  = '{ins(OP_SWI,   8'd0, 3'd4, 8'h00),   1'b1, 8'd0, 8'd5,    32'h10};
        vecs[4]  = '{ins(OP_SWD,   8'd0, 3'd5, 8'd3),    1'b1, 8'd1, 8'd3,    32'h14};
        vecs[5]  = '{ins(OP_ADD,   8'd4, 3'd4, 8'd5),    1'b0, 8'd4, 8'd8,    32'h18};
        vecs[6]  = '{ins(OP_SUB,   8'd5, 3'd4, 8'd5),    1'b0, 8'd5, 8'd5,    32'h1C};
        vecs[7]  = '{ins(OP_LWI,   8'd6, 3'd0, 8'h00),   1'b0, 8'd6, 8'd5,    32'h20};
        vecs[8]  = '{ins(OP_LWD,   8'd7, 3'd0, 8'd3),    1'b0, 8'd7, 8'd3,    32'h24};
        vecs[9]  = '{ins(OP_LOADI, 8'd1, 3'd0, 8'd2),    1'b0, 8'd1, 8'd2,    32'h28};
        vecs[10] = '{ins(OP_LOADI, 8'd2, 3'd0, 8'd5),    1'b0, 8'd2, 8'd5,    32'h2C};
        vecs[11] = '{ins(OP_SUB,   8'd3, 3'd1, 8'd2),    1'b0, 8'd3, 8'hFD,   32'h30};
        vecs[12] = '{ins(OP_LOADI, 8'd1, 3'd0, 8'hF0),   1'b0, 8'd1, 8'hF0,   32'h34};
        vecs[13] = '{ins(OP_LOADI, 8'd2, 3'd0, 8'h3C),   1'b0, 8'd2, 8'h3C,   32'h38};
        vecs[14] = '{ins(OP_AND,   8'd3, 3'd1, 8'd2),    1'b0, 8'd3, 8'h30,   32'h3C};
        vecs[15] = '{ins(OP_OR,    8'd3, 3'd1, 8'd2),    1'b0, 8'd3, 8'hFC,   32'h40};
        vecs[16] = '{ins(OP_LOADI, 8'd2, 3'd0, 8'hAA),   1'b0, 8'd2, 8'hAA,   32'h44};
        vecs[17] = '{ins(OP_MOV,   8'd0, 3'd0, 8'd2),    1'b0, 8'd0, 8'hAA,   32'h48};
        vecs[18] = '{ins(8'h3C,    8'd0, 3'd2, 8'd2),    1'b0, 8'd0, 8'hAA,   32'h4C};

        // Reset state.
        do_reset();
        check("reset_pc", PC, 32'd0);
        check("reset_busy", {31'b0, dut.busywait}, 32'd0);
        for (int i = 0; i < 8; i++) check("reset_reg", {24'b0, dut.u_rf.regs[i]}, 32'd0);
        check("reset_mem0", {24'b0, dut.u_dmem.mem[0]}, 32'd0);
        check("reset_memff", {24'b0, dut.u_dmem.mem[255]}, 32'd0);

        // Directed program with hand-derived results.
        for (int v = 0; v < 19; v++) begin
            run_instr(vecs[v].instr);
            check("vec_pc", PC, vecs[v].pc);
            if (vecs[v].chk_mem)
                check("vec_mem", {24'b0, dut.u_dmem.mem[vecs[v].idx]}, {24'b0, vecs[v].val});
            else
                check("vec_reg", {24'b0, dut.u_rf.regs[vecs[v].idx[2:0]]}, {24'b0, vecs[v].val});
        end

        // Branch and jump sequence, including 32-bit target wrap-around.
        do_reset();
        run_instr(ins(OP_LOADI, 8'd1, 3'd0, 8'd7));
        run_instr(ins(OP_LOADI, 8'd2, 3'd0, 8'd7));
        run_instr(NOP);
        run_instr(NOP);
        check("pre_beq_pc", PC, 32'h10);
        run_instr(ins(OP_BEQ, 8'hFE, 3'd1, 8'd2));
        check("beq_taken", PC, 32'h0C);
        run_instr(ins(OP_LOADI, 8'd2, 3'd0, 8'd6));
        run_instr(ins(OP_BEQ, 8'hFE, 3'd1, 8'd2));
        check("beq_not_taken", PC, 32'h14);
        repeat (3) run_instr(NOP);
        run_instr(ins(OP_J, 8'h01, 3'd0, 8'd0));
        check("j_fwd", PC, 32'h28);
        run_instr(ins(OP_J, 8'h80, 3'd0, 8'd0));
        check("j_wrap_back", PC, 32'hFFFF_FE2C);
        run_instr(ins(OP_J, 8'h7F, 3'd0, 8'd0));
        check("j_wrap_fwd", PC, 32'h0000_002C);

        // Reset in the middle of a store: store must be dropped.
        do_reset();
        run_instr(ins(OP_LOADI, 8'd4, 3'd0, 8'd5));
        INSTRUCTION = ins(OP_SWI, 8'd0, 3'd4, 8'h10);
        if (LAT > 1) begin
            @(posedge CLK);
            #1;
        end
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        INSTRUCTION = NOP;
        model_reset();
        #1;
        check("abort_pc", PC, 32'd0);
        check("abort_mem", {24'b0, dut.u_dmem.mem[8'h10]}, 32'd0);
        check("abort_reg", {24'b0, dut.u_rf.regs[4]}, 32'd0);
        check("abort_busy", {31'b0, dut.busywait}, 32'd0);
        // A fresh store after the abort must pay the full latency again.
        run_instr(ins(OP_LOADI, 8'd4, 3'd0, 8'd9));
        run_instr(ins(OP_SWI, 8'd0, 3'd4, 8'h10));
        check("post_abort_mem", {24'b0, dut.u_dmem.mem[8'h10]}, 32'd9);
        check("post_abort_pc", PC, 32'h08);

        // Random instruction stream against the model.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] instr;
            int          sel;
            instr = $urandom;
            sel = $urandom_range(0, 12);
            if (sel == 12) instr[31:24] = 8'hC0 | 8'($urandom_range(0, 63));
            else instr[31:24] = 8'(sel);
            run_instr(instr);
            check("rnd_pc", PC, m_pc);
            for (int i = 0; i < 8; i++)
                check("rnd_reg", {24'b0, dut.u_rf.regs[i]}, {24'b0, m_reg[i]});
            if (m_st_valid)
                check("rnd_mem", {24'b0, dut.u_dmem.mem[m_st_addr]}, {24'b0, m_mem[m_st_addr]});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
